// File: rtl/muldiv_unit_if.sv
// Issue/completion handshake bundle between the execute stage and muldiv_unit.
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd;
    logic            busy;

    modport master (
        output in_valid, funct3, rs1, rs2, out_ready,
        input  in_ready, out_valid, rd, busy
    );

    modport slave (
        input  in_valid, funct3, rs1, rs2, out_ready,
        output in_ready, out_valid, rd, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide. Operands are reduced to magnitudes at issue,
// processed one bit per cycle (shift-add multiply / restoring divide), then sign-fixed.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN);

    localparam logic [2:0] F3Mul    = 3'd0;
    localparam logic [2:0] F3Mulh   = 3'd1;
    localparam logic [2:0] F3Mulhsu = 3'd2;
    localparam logic [2:0] F3Div    = 3'd4;
    localparam logic [2:0] F3Rem    = 3'd6;

    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic            special_q, special_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    // hi/lo: product halves for multiply; remainder/quotient-shift for divide.
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic            a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    // Issue-time decode: per-op signedness, operand magnitudes and shortcut results.
    always_comb begin
        a_signed = bus.funct3 inside {F3Mul, F3Mulh, F3Mulhsu, F3Div, F3Rem};
        b_signed = bus.funct3 inside {F3Mul, F3Mulh, F3Div, F3Rem};
        sa       = a_signed & bus.rs1[XLEN-1];
        sb       = b_signed & bus.rs2[XLEN-1];
        a_mag    = sa ? -bus.rs1 : bus.rs1;
        b_mag    = sb ? -bus.rs2 : bus.rs2;
        div_zero = bus.funct3[2] && (bus.rs2 == '0);
        div_ovf  = ((bus.funct3 == F3Div) || (bus.funct3 == F3Rem)) &&
                   (bus.rs1 == MinInt) && (bus.rs2 == '1);
        // funct3[1] separates REM/REMU from DIV/DIVU
        if (div_zero) begin
            special_res = bus.funct3[1] ? bus.rs1 : '1;
        end else begin
            special_res = bus.funct3[1] ? '0 : MinInt;
        end
    end

    // One iteration step for each algorithm plus the final sign fix and result select.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        prod_fix  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_fix   = neg_q ? -lo_q : lo_q;
        rem_fix   = neg_q ? -hi_q : hi_q;
        if (special_q) begin
            fix_res = lo_q;
        end else if (op_q[2]) begin
            fix_res = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q == F3Mul) begin
            fix_res = prod_fix[XLEN-1:0];
        end else begin
            fix_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic for the IDLE/CALC/FIX/DONE sequencer and its datapath.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_d       = neg_q;
        special_d   = special_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        rd_d        = rd_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    op_d       = bus.funct3;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    if (div_zero || div_ovf) begin
                        special_d = 1'b1;
                        neg_d     = 1'b0;
                        lo_d      = special_res;
                        state_d   = StFix;
                    end else begin
                        special_d = 1'b0;
                        // quotient sign for DIV, dividend sign for REM, product sign otherwise
                        neg_d     = (bus.funct3[2] && bus.funct3[1]) ? sa : (sa ^ sb);
                        a_d       = a_mag;
                        b_d       = b_mag;
                        hi_d      = '0;
                        lo_d      = bus.funct3[2] ? a_mag : b_mag;
                        cnt_d     = '1;
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                if (op_q[2]) begin
                    if (!div_diff[XLEN]) begin
                        hi_d = div_diff[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[XLEN-1:0];
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StFix: begin
                rd_d    = fix_res;
                state_d = StDone;
            end
            StDone: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            special_q   <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            rd_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            special_q   <= special_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            rd_q        <= rd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.rd        = rd_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, backpressure and async reset.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // Waits for out_valid, counting rising edges since the issue edge (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_rd, input int exp_lat);
        int lat;
        @(negedge clk);
        check_val({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.funct3    = f3;
        bus.rs1       = a;
        bus.rs2       = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_val({tag, " busy"}, 32'({bus.busy, bus.in_ready}), 32'b10);
        wait_valid(lat);
        check_val({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, " rd"}, bus.rd, exp_rd);
        @(posedge clk);
        #1;
        check_val({tag, " complete"}, 32'({bus.out_valid, bus.in_ready, bus.busy}), 32'b010);
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.funct3    = 3'd0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        check_val("reset in_ready", 32'(bus.in_ready), 32'd1);
        check_val("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_val("reset busy", 32'(bus.busy), 32'd0);
        check_val("reset rd", bus.rd, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Multiply family
        run_op("mul 4*6",        3'd0, 32'd4,        32'd6,        32'd24,       34);
        run_op("mul -2*-4",      3'd0, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'd8,        34);
        run_op("mulh min*min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("mulhu max*max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_op("mulhsu -1*max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);

        // Divide family
        run_op("div -8/2",       3'd4, 32'hFFFFFFF8, 32'd2,        32'hFFFFFFFC, 34);
        run_op("divu fff0/3",    3'd5, 32'hFFFFFFF0, 32'd3,        32'h55555550, 34);
        run_op("rem -10,3",      3'd6, 32'hFFFFFFF6, 32'd3,        32'hFFFFFFFF, 34);
        run_op("remu 10,3",      3'd7, 32'd10,       32'd3,        32'd1,        34);

        // Shortcut cases
        run_op("div x/0",        3'd4, 32'd123,      32'd0,        32'hFFFFFFFF, 2);
        run_op("remu 7/0",       3'd7, 32'd7,        32'd0,        32'd7,        2);
        run_op("div min/-1",     3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        run_op("rem min/-1",     3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2);

        // Backpressure: result held, second request ignored
        @(negedge clk);
        bus.funct3    = 3'd0;
        bus.rs1       = 32'd7;
        bus.rs2       = 32'd9;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check_val("bp latency", 32'(lat), 32'd34);
        check_val("bp rd", bus.rd, 32'd63);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.funct3   = 3'd4;
                bus.rs1      = 32'd100;
                bus.rs2      = 32'd5;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check_val("bp hold rd", bus.rd, 32'd63);
            check_val("bp hold flags", 32'({bus.out_valid, bus.in_ready, bus.busy}), 32'b101);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp release", 32'({bus.out_valid, bus.in_ready, bus.busy}), 32'b010);

        // Asynchronous reset mid-calculation
        @(negedge clk);
        bus.funct3    = 3'd3;
        bus.rs1       = 32'hFFFFFFFF;
        bus.rs2       = 32'hFFFFFFFF;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        check_val("pre-rst busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check_val("async rst out_valid", 32'(bus.out_valid), 32'd0);
        check_val("async rst busy", 32'(bus.busy), 32'd0);
        check_val("async rst rd", bus.rd, 32'd0);
        check_val("async rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_op("mul 3*5 after rst", 3'd0, 32'd3, 32'd5, 32'd15, 34);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle RV32M multiply/divide unit that sits beside the single-cycle `alu` in the execute stage. It accepts M-extension operations (funct7 = 0x01) under a valid/ready issue handshake and returns a 32-bit `rd` result under a valid/ready completion handshake. All eight RV32M funct3 encodings are implemented with full RISC-V semantics, including the divide-by-zero and signed-overflow results.

## Interface
- XLEN, 32, operand and result width (only 32 supported)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  issue request valid
- in_ready  out  1  unit can accept; high only in IDLE
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1  in  32  operand A (dividend / multiplicand)
- rs2  in  32  operand B (divisor / multiplier)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- rd  out  32  result, held stable while out_valid is high
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid, latch funct3 and operands, record result sign, convert signed operands to magnitudes (signedness per op: MUL/MULH/DIV/REM both signed, MULHSU rs1 only, MULHU/DIVU/REMU none), load count=31 and go to CALC.
- Special cases detected at issue, bypassing CALC straight to FIX:
  - Divide by zero (rs2=0, funct3 4-7): DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- CALC, one iteration per cycle for 32 cycles:
  - Multiply: shift-add into a 64-bit unsigned product.
  - Divide: restoring division into a 32-bit quotient and remainder.
  - Exits to FIX after the count reaches 0.
- FIX (one cycle):
  - Multiply sign fix: negate the 64-bit product if the sign is negative. MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits.
  - Divide sign fix: quotient sign is sign(rs1) XOR sign(rs2); remainder takes the sign of rs1.
  - Register `rd` and go to DONE.
- DONE: out_valid=1. Go to IDLE on out_ready.
- funct7 is not an input. The decoder steers only funct7=0x01 operations here.
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, rd=0. An in-flight operation is discarded with no result produced.

## Timing
- Issue fires on the edge where in_valid && in_ready. Call this edge E0.
- Normal path: CALC occupies E0+1 .. E0+32, FIX at E0+33, out_valid rises after edge E0+34. Latency is 34 cycles.
- Special-case path: FIX at E0+1, out_valid rises after edge E0+2.
- out_valid and rd hold indefinitely until out_ready. The handshake completes on the edge where out_valid && out_ready.
- in_ready is low from E0 until the completion edge, then high the next cycle. There is no back-to-back issue on the completion edge.
- in_valid while busy is ignored. No operand or funct3 change is observed mid-operation.
- rst asserted mid-CALC forces outputs to reset values immediately, without waiting for clk.

## Test plan
- Basic MUL and MULH:
  - MUL rs1=4, rs2=6 -> rd=24 at latency 34.
  - MUL rs1=-2, rs2=-4 -> rd=8.
  - MULH rs1=rs2=0x80000000 -> rd=0x40000000.
- Upper-half variants:
  - MULHU rs1=rs2=0xFFFFFFFF -> rd=0xFFFFFFFE.
  - MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> rd=0xFFFFFFFF.
- Divide and remainder:
  - DIV -8/2 -> rd=0xFFFFFFFC.
  - DIVU 0xFFFFFFF0/3 -> rd=0x55555550.
  - REM -10,3 -> rd=0xFFFFFFFF.
  - REMU 10,3 -> rd=1.
- Special cases, each completing at latency 2:
  - DIV x/0 -> rd=0xFFFFFFFF.
  - REMU 7/0 -> rd=7.
  - DIV 0x80000000/-1 -> rd=0x80000000.
  - REM 0x80000000/-1 -> rd=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid. rd stays constant, in_ready stays 0, and a second in_valid is ignored.
  - Release out_ready; the next cycle in_ready=1.
- Reset mid-operation:
  - Assert rst at E0+15 between clock edges. out_valid, busy and rd are 0 and in_ready is 1 immediately.
  - After release, a new MUL 3*5 returns 15.
